// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word/mask types plus the memory arbiter state encoding.
package lc3b_types;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } lc3b_arb_state;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch (I) and data (D),
// D-priority with a starvation bound that forces I in after MAX_D_RUN D grants.
module mem_arbiter
    import lc3b_types::*;
#(
    parameter int MAX_D_RUN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_read,
    input  lc3b_word      i_address,
    output lc3b_word      i_rdata,
    output logic          i_resp,
    input  logic          d_read,
    input  logic          d_write,
    input  lc3b_word      d_address,
    input  lc3b_word      d_wdata,
    input  lc3b_mem_wmask d_byte_enable,
    output lc3b_word      d_rdata,
    output logic          d_resp,
    output logic          mem_read,
    output logic          mem_write,
    output lc3b_mem_wmask mem_byte_enable,
    output lc3b_word      mem_address,
    output lc3b_word      mem_wdata,
    input  lc3b_word      mem_rdata,
    input  logic          mem_resp
);

    lc3b_arb_state state;
    logic [3:0]    d_run;
    logic          cap_read, cap_write;
    lc3b_word      cap_address, cap_wdata;
    lc3b_mem_wmask cap_byte_enable;
    logic          d_req, grant_d, grant_i, busy, serve_i, serve_d;

    assign d_req   = d_read | d_write;
    assign grant_d = (state == ARB_IDLE) && d_req && (!i_read || d_run < 4'(MAX_D_RUN));
    assign grant_i = (state == ARB_IDLE) && !grant_d && i_read;
    assign serve_i = state == ARB_SERVE_I;
    assign serve_d = state == ARB_SERVE_D;
    assign busy    = serve_i | serve_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= ARB_IDLE;
            d_run           <= '0;
            cap_read        <= 1'b0;
            cap_write       <= 1'b0;
            cap_address     <= '0;
            cap_wdata       <= '0;
            cap_byte_enable <= '0;
        end else if (grant_d) begin
            state           <= ARB_SERVE_D;
            d_run           <= i_read ? (d_run == 4'hf ? d_run : d_run + 4'd1) : 4'd0;
            cap_read        <= d_read & ~d_write;
            cap_write       <= d_write;
            cap_address     <= d_address;
            cap_wdata       <= d_wdata;
            cap_byte_enable <= d_byte_enable;
        end else if (grant_i) begin
            state           <= ARB_SERVE_I;
            d_run           <= '0;
            cap_read        <= 1'b1;
            cap_write       <= 1'b0;
            cap_address     <= i_address;
            cap_wdata       <= '0;
            cap_byte_enable <= 2'b11;
        end else if (busy && mem_resp) begin
            state <= ARB_IDLE;
        end
    end

    // Memory side is gated by busy so stale captures never leak out in IDLE.
    assign mem_read        = busy & cap_read;
    assign mem_write       = busy & cap_write;
    assign mem_address     = busy ? cap_address : '0;
    assign mem_wdata       = busy ? cap_wdata : '0;
    assign mem_byte_enable = busy ? cap_byte_enable : '0;

    assign i_resp  = serve_i & mem_resp;
    assign d_resp  = serve_d & mem_resp;
    assign i_rdata = serve_i ? mem_rdata : '0;
    assign d_rdata = serve_d ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter against a small latency-driven memory responder.
module tb_mem_arbiter;
    import lc3b_types::*;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          i_read = 1'b0, d_read = 1'b0, d_write = 1'b0;
    lc3b_word      i_address = '0, d_address = '0, d_wdata = '0;
    lc3b_mem_wmask d_byte_enable = '0;
    lc3b_word      i_rdata, d_rdata, mem_address, mem_wdata, mem_rdata;
    logic          i_resp, d_resp, mem_read, mem_write, mem_resp;
    lc3b_mem_wmask mem_byte_enable;

    int       checks = 0, errors = 0;
    int       lat = 3, cnt = 0;
    logic     resp_q = 1'b0, spur = 1'b0;
    lc3b_word rdata_val = 16'h0000;
    logic     got;
    logic [4:0] seq;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_D_RUN(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_byte_enable(d_byte_enable), .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_byte_enable(mem_byte_enable),
        .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_resp(mem_resp)
    );

    // Memory responder: asserts resp for one cycle after lat cycles of strobe.
    always @(posedge clk) begin
        if (resp_q || !(mem_read || mem_write)) begin
            resp_q <= 1'b0;
            cnt    <= 0;
        end else if (cnt == lat - 1) begin
            resp_q <= 1'b1;
            cnt    <= 0;
        end else begin
            cnt <= cnt + 1;
        end
    end
    assign mem_resp  = resp_q | spur;
    assign mem_rdata = rdata_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(input bit want_d, output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (want_d ? d_resp : i_resp) begin
                ok = 1'b1;
                return;
            end
        end
        chk(want_d ? "d_resp_timeout" : "i_resp_timeout", 0, 1);
    endtask

    task automatic wait_any(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (d_resp || i_resp) begin
                ok = 1'b1;
                return;
            end
        end
        chk("any_resp_timeout", 0, 1);
    endtask

    initial begin
        #2;
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_address", 32'(mem_address), 0);
        chk("rst_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("rst_d_run", 32'(dut.d_run), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // I read with latency 3
        @(negedge clk);
        lat = 3; rdata_val = 16'h1234;
        i_read = 1'b1; i_address = 16'h0040;
        #1 chk("t1_mem_read_early", 32'(mem_read), 0);
        @(negedge clk);
        chk("t1_mem_read", 32'(mem_read), 1);
        chk("t1_mem_address", 32'(mem_address), 32'h0040);
        chk("t1_mem_be", 32'(mem_byte_enable), 2'b11);
        wait_resp(1'b0, got);
        chk("t1_i_rdata", 32'(i_rdata), 32'h1234);
        chk("t1_d_resp", 32'(d_resp), 0);
        i_read = 1'b0;
        @(negedge clk);
        chk("t1_i_resp_once", 32'(i_resp), 0);
        chk("t1_turn_read", 32'(mem_read), 0);

        // simultaneous I and D write: D first
        rdata_val = 16'h7777;
        i_read = 1'b1; i_address = 16'h0080;
        d_write = 1'b1; d_address = 16'h0100; d_wdata = 16'hBEEF; d_byte_enable = 2'b01;
        @(negedge clk);
        chk("t2_mem_write", 32'(mem_write), 1);
        chk("t2_mem_read", 32'(mem_read), 0);
        chk("t2_mem_address", 32'(mem_address), 32'h0100);
        chk("t2_mem_be", 32'(mem_byte_enable), 2'b01);
        chk("t2_mem_wdata", 32'(mem_wdata), 32'hBEEF);
        wait_resp(1'b1, got);
        d_write = 1'b0;
        @(negedge clk);
        chk("t2_idle_read", 32'(mem_read), 0);
        chk("t2_idle_write", 32'(mem_write), 0);
        @(negedge clk);
        chk("t2_i_read", 32'(mem_read), 1);
        chk("t2_i_address", 32'(mem_address), 32'h0080);
        wait_resp(1'b0, got);
        chk("t2_i_rdata", 32'(i_rdata), 32'h7777);
        i_read = 1'b0;
        @(negedge clk);

        // starvation bound: D,D,D,D then I
        lat = 1;
        i_read = 1'b1; i_address = 16'h00C0;
        d_read = 1'b1; d_address = 16'h0300;
        seq = '0;
        for (int n = 0; n < 5; n++) begin
            wait_any(got);
            seq = {seq[3:0], d_resp};
            if (n == 3) chk("t3_d_run_sat", 32'(dut.d_run), 4);
        end
        chk("t3_grant_seq", 32'(seq), 32'b11110);
        chk("t3_d_run_clear", 32'(dut.d_run), 0);
        i_read = 1'b0; d_read = 1'b0;
        @(negedge clk);

        // read+write together, address changes mid-transaction
        lat = 3;
        d_read = 1'b1; d_write = 1'b1; d_address = 16'h0400; d_wdata = 16'h5555; d_byte_enable = 2'b11;
        @(negedge clk);
        chk("t4_mem_write", 32'(mem_write), 1);
        chk("t4_mem_read", 32'(mem_read), 0);
        d_address = 16'h0200;
        for (int k = 0; k < 20 && !d_resp; k++) begin
            chk("t4_addr_hold", 32'(mem_address), 32'h0400);
            @(negedge clk);
        end
        chk("t4_d_resp", 32'(d_resp), 1);
        chk("t4_addr_at_resp", 32'(mem_address), 32'h0400);
        d_read = 1'b0; d_write = 1'b0;
        @(negedge clk);

        // spurious mem_resp in IDLE
        spur = 1'b1;
        #1;
        chk("t5_i_resp", 32'(i_resp), 0);
        chk("t5_d_resp", 32'(d_resp), 0);
        @(negedge clk);
        spur = 1'b0;
        chk("t5_state", 32'(dut.state), 32'(ARB_IDLE));
        chk("t5_mem_read", 32'(mem_read), 0);

        // reset during SERVE_I
        lat = 6; rdata_val = 16'hA5A5;
        i_read = 1'b1; i_address = 16'h0500;
        @(negedge clk);
        chk("t6_mem_read", 32'(mem_read), 1);
        rst_n = 1'b0;
        #1;
        chk("t6_async_drop", 32'(mem_read), 0);
        chk("t6_no_resp", 32'(i_resp), 0);
        @(negedge clk);
        chk("t6_no_resp_held", 32'(i_resp), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_regrant", 32'(mem_read), 1);
        chk("t6_regrant_addr", 32'(mem_address), 32'h0500);
        wait_resp(1'b0, got);
        chk("t6_i_rdata", 32'(i_rdata), 32'hA5A5);
        i_read = 1'b0;
        @(negedge clk);
        chk("t6_final_idle", 32'(mem_read), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single LC-3b physical memory port between an instruction-fetch requester (I, read-only) and a data requester (D, read/write).
- Sits between the fetch/load-store front end and the memory model. The memory side reuses the existing mem_* signal set unchanged.
- Policy: D has priority, with a starvation limit that guarantees I a grant after a bounded run of D grants.
- One memory transaction is outstanding at a time.

Parameters:
- MAX_D_RUN, 4, maximum consecutive D grants while I is waiting before I is forced in (legal range 1..15).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_read  in  1  I request (held until i_resp)
- i_address  in  16  lc3b_word fetch address
- i_rdata  out  16  lc3b_word read data to I
- i_resp  out  1  one-cycle completion pulse to I
- d_read  in  1  D read request (held until d_resp)
- d_write  in  1  D write request (held until d_resp)
- d_address  in  16  lc3b_word data address
- d_wdata  in  16  lc3b_word write data
- d_byte_enable  in  2  lc3b_mem_wmask write mask
- d_rdata  out  16  lc3b_word read data to D
- d_resp  out  1  one-cycle completion pulse to D
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_byte_enable  out  2  lc3b_mem_wmask
- mem_address  out  16  lc3b_word
- mem_wdata  out  16  lc3b_word
- mem_rdata  in  16  lc3b_word
- mem_resp  in  1  memory completion

Behaviour:
- Reset (async, rst_n=0):
  - State is IDLE; d_run counter is 0.
  - All mem_* outputs are 0; i_resp and d_resp are 0.
  - Captured request registers are 0.
- States and transitions:
  - IDLE: d_req = d_read|d_write.
    - If d_req and (!i_read or d_run < MAX_D_RUN): go to SERVE_D and capture D's request.
    - Else if i_read: go to SERVE_I and capture I's request.
    - Else: stay in IDLE.
  - SERVE_I / SERVE_D: drive mem_* from the captured registers. On mem_resp=1, go to IDLE.
- Capture at grant:
  - address, wdata, byte_enable, read, write are registered at the IDLE->SERVE edge.
  - mem_* are driven only from these registers, so requester changes mid-transaction have no effect.
  - For I: mem_write=0, mem_byte_enable=2'b11, mem_wdata=0.
- d_run counter:
  - Increments (saturating at 15) on each D grant made while i_read=1.
  - Clears to 0 on every I grant.
  - Clears on a D grant made while i_read=0.
- Response:
  - In SERVE_x, x_resp = mem_resp (combinational pass-through, a one-cycle pulse). The other requester's resp is 0.
  - x_rdata = mem_rdata whenever the state is SERVE_x; otherwise x_rdata = 0.
- Turnaround:
  - The cycle after mem_resp is always IDLE, with mem_read=mem_write=0.
  - Minimum transaction is 2 cycles plus memory latency.
  - A requester updates or drops its request on the edge where it samples resp. IDLE then arbitrates on post-resp values, so there is no duplicate service.
- Simultaneous d_read and d_write: the write wins (mem_write=1, mem_read=0).
- mem_resp while in IDLE: ignored; no resp is forwarded.
- Reset asserted mid-transaction: immediate return to IDLE. Strobes drop asynchronously and the in-flight access is abandoned without any resp.

Decomposition:
- Add to lc3b_types: a 2-bit enum lc3b_arb_state {ARB_IDLE, ARB_SERVE_I, ARB_SERVE_D}.
- Reuse lc3b_word and lc3b_mem_wmask.
- No sub-module: the FSM, counter and capture registers live in one module.
- Instantiated in mp1 in place of the direct memory connection.

Test Plan:
- Reset, then I reads 0x0040 with memory latency 3 and mem_rdata=0x1234:
  - mem_read rises 1 cycle after i_read.
  - i_resp pulses once with i_rdata=0x1234.
  - d_resp stays 0.
- i_read and d_write (addr 0x0100, wdata 0xBEEF, mask 2'b01) asserted in the same cycle:
  - D is served first: mem_write=1, mem_address=0x0100, mem_byte_enable=2'b01.
  - One IDLE cycle follows, then I is served.
- MAX_D_RUN=4, with D issuing back-to-back reads while i_read is held:
  - Exactly 4 D grants occur, then an I grant.
  - d_run reads 0 after the I grant.
- d_read and d_write both high, with d_address changed to 0x0200 during SERVE_D:
  - mem_write=1 and mem_read=0.
  - mem_address holds the captured value (not 0x0200) until mem_resp.
- Spurious mem_resp=1 in IDLE with no requests:
  - No i_resp or d_resp; state stays IDLE.
- rst_n pulled low for 1 cycle during SERVE_I:
  - mem_read drops asynchronously and no i_resp is issued.
  - After release, the still-held i_read is re-granted and completes normally.
